// File: rtl/lca_pkg.sv
// Shared defaults and result record for the lookahead-carry adder result path.
package lca_pkg;

    localparam int unsigned LCA_WIDTH   = 64;
    localparam int unsigned LCA_LATENCY = 4;
    localparam int unsigned LCA_DEPTH   = 8;

    typedef struct packed {
        logic                 cout;
        logic [LCA_WIDTH-1:0] sum;
    } lca_result_t;

endpackage

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO; head is read combinationally from storage.
module sync_fwft_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    assign w_do_rd = i_rd_en && !o_empty;
    // A write into a full FIFO is only legal when the head leaves on the same edge.
    assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_wr) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_wr && !w_do_rd) begin
                r_count <= r_count + CW'(1);
            end else if (!w_do_wr && w_do_rd) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/lca_result_collector.sv
// Turns the free-running fixed-latency adder pipe into a valid/ready result stream,
// issuing upstream credit so buffered plus in-flight results never exceed DEPTH.
module lca_result_collector
    import lca_pkg::*;
#(
    parameter int unsigned WIDTH   = LCA_WIDTH,
    parameter int unsigned LATENCY = LCA_LATENCY,
    parameter int unsigned DEPTH   = LCA_DEPTH,
    localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cout_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [CW-1:0]    occupancy,
    output logic             ovf_err
);

    logic [LATENCY-1:0] r_tag;
    logic [CW-1:0]      r_inflight;
    logic               r_ovf;
    logic [CW-1:0]      w_fifo_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [WIDTH:0]     w_head;
    logic [CW:0]        w_occ_wide;
    logic               w_accept;
    logic               w_capture;
    logic               w_pop;

    assign w_occ_wide  = {1'b0, w_fifo_count} + {1'b0, r_inflight};
    assign issue_ready = (w_occ_wide < (CW + 1)'(DEPTH));
    assign occupancy   = w_occ_wide[CW-1:0];

    assign w_accept  = issue_valid && issue_ready;
    assign w_capture = r_tag[LATENCY-1];
    assign w_pop     = out_valid && out_ready;

    assign out_valid = !w_fifo_empty;
    assign out_sum   = w_head[WIDTH-1:0];
    assign out_cout  = w_head[WIDTH];
    assign ovf_err   = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag      <= '0;
            r_inflight <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_tag[0] <= w_accept;
            for (int k = 1; k < int'(LATENCY); k++) begin
                r_tag[k] <= r_tag[k-1];
            end
            if (w_accept && !w_capture) begin
                r_inflight <= r_inflight + CW'(1);
            end else if (!w_accept && w_capture) begin
                r_inflight <= r_inflight - CW'(1);
            end
            if (w_capture && w_fifo_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    sync_fwft_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_capture),
        .i_wr_data ({cout_in, sum_in}),
        .i_rd_en   (out_ready),
        .o_rd_data (w_head),
        .o_count   (w_fifo_count),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

endmodule
